seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Display stage directly downstream of the per-candidate BCD digit counters in the ballot box.
- Snapshots a packed vector of BCD digits on command.
- Drives a time-multiplexed, common-anode 7-segment display: one digit lit at a time, with a guard cycle between digits to prevent ghosting.
- Nibbles above 9 (counter corruption) are shown as a dash.

Parameters:
- DIGITS, 4, number of BCD digits and anode lines.
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- DIV_W, 16, width of the prescaler; must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- digits_in  input  4*DIGITS  packed BCD digits; digit 0 (least significant) is [3:0].
- load  input  1  single-cycle strobe; captures digits_in into the snapshot.
- blank  input  1  level input; forces the display dark.
- anode  output  DIGITS  active-low digit enables; anode[0] is digit 0.
- seg  output  7  active-low segments; seg[6]=a through seg[0]=g.

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is asynchronous, active-high.
- Reset state, applied immediately with no clock edge needed:
  - snapshot = 0, prescaler = 0, index = 0
  - anode = all 1s, seg = 7'h7F
- Reset deassertion: scanning starts at digit 0. The first output update occurs on the first clock edge after release.
- Snapshot:
  - On an edge with load=1, snapshot <= digits_in.
  - The new value is used from the next output update onward.
  - load has no effect while reset is asserted.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where prescaler==SCAN_DIV-1, index advances: 0→1→…→DIGITS-1→0.
- Slot timing (anode and seg are registered, glitch-free, and change only on clock edges):
  - Each digit slot is SCAN_DIV cycles long.
  - Cycle 0 of the slot is a guard cycle: anode = all 1s, seg = 7'h7F.
  - Cycles 1..SCAN_DIV-1: anode has only bit [index] low; seg = decode(snapshot nibble[index]).
  - Full scan period = DIGITS*SCAN_DIV cycles.
- Decode (active-low):
  - 0→01, 1→4F, 2→12, 3→06, 4→4C, 5→24, 6→20, 7→0F, 8→00, 9→04 (hex)
  - 10–15 → 7E (segment g only, dash)
- blank:
  - When sampled high, anode = all 1s and seg = 7'h7F from the next cycle, for as long as blank stays high.
  - The prescaler and index keep running.
  - On release, the display resumes in the correct phase with no restart.
- Simultaneous events:
  - load together with prescaler wrap: both take effect; the next slot shows the new snapshot.
  - load together with blank: the snapshot is still captured.
- Reset mid-scan: all state clears at once; no partial slot is completed.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i (i >= 1) is suppressed when nibble i and every higher nibble are 0. During a suppressed slot, anode = all 1s and seg = 7'h7F.
  - Digit 0 is never suppressed.
  - Slot timing is unchanged.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan (DIGITS=4, SCAN_DIV=4):
1. Reset and release:
   - Stimulus: assert reset with no clock running.
   - Required: anode=4'hF and seg=7'h7F immediately. After release, the first lit slot shows digit 0 with value 0: anode=4'b1110, seg=7'h01.
2. Load and full scan:
   - Stimulus: digits_in=16'h1234, load pulsed for one cycle.
   - Required, for each digit: 1 guard cycle, then 3 cycles of 4/4C @ 1110, 3/06 @ 1101, 2/12 @ 1011, 1/4F @ 0111. Pattern repeats every 16 cycles.
3. Out-of-range nibble:
   - Stimulus: digits_in=16'h00A0, load.
   - Required: digit 1 slot shows seg=7'h7E with anode=4'b1101.
4. Blank mid-slot:
   - Stimulus: blank high for 6 cycles, then low.
   - Required: anode=4'hF from the cycle after blank is sampled high. After release, index equals the value it would have had if blank had never been asserted.
5. Load at prescaler wrap, then async reset:
   - Stimulus: load 16'h9999 on the wrap edge.
   - Required: the next slot shows 7'h04.
   - Stimulus: then assert reset between clock edges.
   - Required: anode=4'hF and seg=7'h7F immediately; snapshot reads 0 after release.
6. With SEG7_LEADING_ZERO_BLANK_EN defined:
   - Stimulus: snapshot 16'h0050.
   - Required: digits 3 and 2 are dark (anode=4'hF throughout their slots); digit 1 shows 24; digit 0 shows 01.
   - Stimulus: snapshot 16'h0000.
   - Required: only digit 0 lit, showing 01.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Scanned common-anode 7-segment driver that snapshots BCD digits and shows one digit per slot, with a guard cycle between slots.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic LZB_EN = 1'b1;
`else
    localparam logic LZB_EN = 1'b0;
`endif

    // Active-low segment pattern; any nibble above 9 becomes a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h01;
            4'd1:    pat = 7'h4F;
            4'd2:    pat = 7'h12;
            4'd3:    pat = 7'h06;
            4'd4:    pat = 7'h4C;
            4'd5:    pat = 7'h24;
            4'd6:    pat = 7'h20;
            4'd7:    pat = 7'h0F;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h04;
            default: pat = 7'h7E;
        endcase
        return pat;
    endfunction

    logic [4*DIGITS-1:0] snapshot_r;
    logic [DIV_W-1:0]    prescaler_r;
    logic [IDX_W-1:0]    index_r;
    logic [DIGITS-1:0]   anode_r;
    logic [6:0]          seg_r;

    logic [DIV_W-1:0]    presc_next_s;
    logic [IDX_W-1:0]    index_next_s;
    logic [4*DIGITS-1:0] shifted_s;
    logic                suppress_s;
    logic                dark_s;

    // Next prescaler/index and the display decision for the state being entered.
    // Digit i and all higher nibbles are zero exactly when the snapshot shifted down by i digits is zero.
    always_comb begin
        presc_next_s = '0;
        index_next_s = index_r;
        if (prescaler_r == DIV_W'(SCAN_DIV - 1)) begin
            presc_next_s = '0;
            if (index_r == IDX_W'(DIGITS - 1)) begin
                index_next_s = '0;
            end else begin
                index_next_s = index_r + IDX_W'(1);
            end
        end else begin
            presc_next_s = prescaler_r + DIV_W'(1);
            index_next_s = index_r;
        end
        shifted_s  = snapshot_r >> {index_next_s, 2'b00};
        suppress_s = LZB_EN && (index_next_s != '0) && (shifted_s == '0);
        dark_s     = blank || (presc_next_s == '0) || suppress_s;
    end

    // Scan state, snapshot capture and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot_r  <= '0;
            prescaler_r <= '0;
            index_r     <= '0;
            anode_r     <= '1;
            seg_r       <= 7'h7F;
        end else begin
            prescaler_r <= presc_next_s;
            index_r     <= index_next_s;
            if (load) begin
                snapshot_r <= digits_in;
            end
            if (dark_s) begin
                anode_r <= '1;
                seg_r   <= 7'h7F;
            end else begin
                anode_r <= ~(DIGITS'(1) << index_next_s);
                seg_r   <= bcd_to_seg(shifted_s[3:0]);
            end
        end
    end

    assign anode = anode_r;
    assign seg   = seg_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: the driver pushes expected outputs from a cycle-count model, and a monitor compares them after each edge.
module tb_seg7_scan_mux;
    localparam int D  = 4;
    localparam int SD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic        blank;
    logic [15:0] digits_in;
    logic [3:0]  anode;
    logic [6:0]  seg;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
    } exp_t;

    exp_t        q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          n;
    logic [15:0] snap;
    logic [6:0]  dec_tab[16];

    seg7_scan_mux #(.DIGITS(D), .SCAN_DIV(SD), .DIV_W(16)) dut (
        .clock(clock), .reset(reset), .digits_in(digits_in),
        .load(load), .blank(blank), .anode(anode), .seg(seg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] a, input logic [6:0] s,
                         input logic [3:0] ea, input logic [6:0] es);
        vectors++;
        if (a !== ea || s !== es) begin
            miscompares++;
            $display("FAIL %s @%0t: got anode=%b seg=%h, want anode=%b seg=%h", name, $time, a, s, ea, es);
        end
    endtask

    // A digit is suppressed when it and every higher digit are zero (never digit 0).
    function automatic bit suppressed(input int idx, input logic [15:0] sn);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx == 0) return 1'b0;
        for (int j = idx; j < D; j++) begin
            if (sn[4*j +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive inputs at the falling edge and predict the output after the next rising edge.
    task automatic step(input bit rst, input bit ld, input logic [15:0] din, input bit blk);
        exp_t e;
        int   p;
        int   idx;
        @(negedge clock);
        load      = ld;
        digits_in = din;
        blank     = blk;
        if (rst) begin
            if (!reset) begin
                reset = 1'b1;
                #1;
                check("async_reset", anode, seg, 4'hF, 7'h7F);
            end
            n    = 0;
            snap = 16'h0000;
            e.an = 4'hF;
            e.sg = 7'h7F;
        end else begin
            reset = 1'b0;
            n++;
            p   = n % SD;
            idx = (n / SD) % D;
            if (blk || p == 0 || suppressed(idx, snap)) begin
                e.an = 4'hF;
                e.sg = 7'h7F;
            end else begin
                e.an      = 4'hF;
                e.an[idx] = 1'b0;
                e.sg      = dec_tab[snap[4*idx +: 4]];
            end
            if (ld) snap = din;
        end
        q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scan", anode, seg, e.an, e.sg);
            end
        end
    end

    initial begin
        logic [15:0] r16;
        dec_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
        reset     = 1'b1;
        load      = 1'b0;
        blank     = 1'b0;
        digits_in = 16'h0000;
        n         = 0;
        snap      = 16'h0000;
        #1;
        check("reset_no_clock", anode, seg, 4'hF, 7'h7F);
        repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b0);

        repeat (20) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        repeat (40) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h00A0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 16'h0000, 1'b0);

        // Blank asserted mid-slot for six cycles.
        while (n % SD != 1) step(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (6) step(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (20) step(1'b0, 1'b0, 16'h0000, 1'b0);

        // Load on the prescaler wrap edge, then reset mid-scan.
        while (n % SD != SD - 1) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h9999, 1'b0);
        repeat (2 * SD + 1) step(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b0);
        repeat (2 * SD * D) step(1'b0, 1'b0, 16'h0000, 1'b0);

        step(1'b0, 1'b1, 16'h0050, 1'b0);
        repeat (2 * SD * D) step(1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        repeat (2 * SD * D) step(1'b0, 1'b0, 16'h0000, 1'b0);

        // Random traffic; digits are biased toward leading zeros.
        for (int i = 0; i < 500; i++) begin
            r16 = 16'($urandom);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 7) == 0,
                 r16 >> (4 * $urandom_range(0, 4)), $urandom_range(0, 5) == 0);
        end

        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
